// File: rtl/vga_pkg.sv
// Shared video constants and types for the framebuffer path.
// Holds the screen geometry, the default VRAM bus widths and the source
// tag that travels alongside each RAM read.
package vga_pkg;

  localparam int HD           = 640;
  localparam int VD           = 480;
  localparam int FB_WORDS_DEF = HD * VD;
  localparam int AW_DEF       = 19;
  localparam int DW_DEF       = 8;

  // Who is waiting for the data coming back from the RAM next cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DISP,
    SRC_H0,
    SRC_H1
  } src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way host arbiter with a preference pointer.
// Build option VRAM_ROUND_ROBIN_EN: when defined, the pointer flips to the
// other host after every grant (round-robin). When undefined, the pointer
// stays at host 0, which gives fixed priority host 0 over host 1.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;  // host preferred when both request

  // Grant the preferred host if it asks, otherwise the other one.
  always_comb begin
    // NOTE: default every output first so no path through the block leaves
    // gnt unassigned; that is what keeps this from becoming a latch.
    gnt = 2'b00;
    if (en) begin
      if (req[ptr]) begin
        gnt[ptr] = 1'b1;
      end else if (req[~ptr]) begin
        gnt[~ptr] = 1'b1;
      end
    end
  end

  // Move the preference after each grant.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (reset) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
`ifdef VRAM_ROUND_ROBIN_EN
      ptr <= gnt[0];
`else
      ptr <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout reads win every visible pixel
// slot; all other cycles go to the CPU/blitter hosts through rr_arbiter2.
// Host sharing policy is selected by VRAM_ROUND_ROBIN_EN (see rr_arbiter2).
// h_gnt is combinational in the decision cycle; the chosen access is
// registered onto mem_* and the RAM returns data while mem_addr is shown,
// so read data is captured one clock later into disp_data / h_rdata.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int FB_WORDS = FB_WORDS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_tick,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic [1:0]    h_req,
  input  logic [1:0]    h_we,
  input  logic [AW-1:0] h_addr0,
  input  logic [AW-1:0] h_addr1,
  input  logic [DW-1:0] h_wdata0,
  input  logic [DW-1:0] h_wdata1,
  output logic [1:0]    h_gnt,
  output logic [1:0]    h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          disp_slot;
  logic          host_en;
  logic [AW-1:0] disp_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] disp_addr_nxt;
  src_t          tag;

  // Display owns the slot on visible pixel ticks; hosts get every other
  // cycle. Both are held off while reset is high so h_gnt stays quiet.
  assign disp_slot = pixel_tick & video_on & ~reset;
  assign host_en   = ~reset & ~(pixel_tick & video_on);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (host_en),
    .req   (h_req),
    .gnt   (h_gnt)
  );

  // Scanout address for this slot (frame_start forces word 0) and its wrapped successor.
  always_comb begin
    rd_addr       = frame_start ? '0 : disp_addr;
    disp_addr_nxt = (rd_addr == AW'(FB_WORDS - 1)) ? '0 : rd_addr + AW'(1);
  end

  // Issue the winning access onto the RAM bus and tag reads with their owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      disp_addr <= '0;
      tag       <= SRC_NONE;
    end else if (disp_slot) begin
      mem_addr  <= rd_addr;
      mem_we    <= 1'b0;
      disp_addr <= disp_addr_nxt;
      tag       <= SRC_DISP;
    end else begin
      if (frame_start) begin
        disp_addr <= '0;
      end
      if (h_gnt[0]) begin
        mem_addr  <= h_addr0;
        mem_we    <= h_we[0];
        mem_wdata <= h_wdata0;
        tag       <= h_we[0] ? SRC_NONE : SRC_H0;
      end else if (h_gnt[1]) begin
        mem_addr  <= h_addr1;
        mem_we    <= h_we[1];
        mem_wdata <= h_wdata1;
        tag       <= h_we[1] ? SRC_NONE : SRC_H1;
      end else begin
        // Idle: no write, address held to avoid needless bus toggling.
        mem_we <= 1'b0;
        tag    <= SRC_NONE;
      end
    end
  end

  // Route returning RAM data to the display or to the host that asked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
      h_rdata    <= '0;
      h_rvalid   <= 2'b00;
    end else begin
      disp_valid <= (tag == SRC_DISP);
      h_rvalid   <= {tag == SRC_H1, tag == SRC_H0};
      if (tag == SRC_DISP) begin
        disp_data <= mem_rdata;
      end
      if ((tag == SRC_H0) || (tag == SRC_H1)) begin
        h_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: random and directed traffic, a reference model
// that predicts grants, RAM accesses and read returns, and a monitor that
// matches those predictions against what the DUT presents.
// The RAM model treats mem_addr as the RAM's own address register: data for
// the shown address is on mem_rdata in the same cycle; writes land mid-cycle.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int AW     = 19;
  localparam int DW     = 8;
  localparam int TB_FB  = 640;  // small frame so the wrap is reached quickly
  localparam int MEM_SZ = 1 << AW;
`ifdef VRAM_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pixel_tick = 1'b0;
  logic          video_on = 1'b0;
  logic          frame_start = 1'b0;
  logic [1:0]    h_req = '0;
  logic [1:0]    h_we = '0;
  logic [AW-1:0] h_addr0 = '0;
  logic [AW-1:0] h_addr1 = '0;
  logic [DW-1:0] h_wdata0 = '0;
  logic [DW-1:0] h_wdata1 = '0;
  logic [1:0]    h_gnt;
  logic [1:0]    h_rvalid;
  logic [DW-1:0] h_rdata;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.AW(AW), .DW(DW), .FB_WORDS(TB_FB)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .frame_start(frame_start),
    .h_req      (h_req),
    .h_we       (h_we),
    .h_addr0    (h_addr0),
    .h_addr1    (h_addr1),
    .h_wdata0   (h_wdata0),
    .h_wdata1   (h_wdata1),
    .h_gnt      (h_gnt),
    .h_rvalid   (h_rvalid),
    .h_rdata    (h_rdata),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 37) ^ (i >> 5) ^ 8'h5C);
  endfunction

  // Device-side RAM.
  logic [DW-1:0] ram [MEM_SZ];
  assign mem_rdata = ram[mem_addr];
  initial begin
    for (int i = 0; i < MEM_SZ; i++) ram[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            cyc;
    int            host;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t acc_q[$];
  exp_t disp_q[$];
  exp_t rd_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string got, input string want, input int when);
    n_checks++;
    n_fail++;
    $display("FAIL %s cyc=%0d got=%s want=%s@%0d", name, cyc, got, want, when);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      check("reset_outputs",
            64'({h_gnt, h_rvalid, h_rdata, disp_data, disp_valid, mem_addr, mem_we, mem_wdata}),
            64'(0));
    end else begin
      // grants
      while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
        fail_event("gnt_missing", "none", "grant", gnt_q[0].cyc);
        void'(gnt_q.pop_front());
      end
      if (h_gnt != 2'b00) begin
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
          e = gnt_q.pop_front();
          check("h_gnt", 64'(h_gnt), 64'(2'b01 << e.host));
        end else begin
          fail_event("gnt_unexpected", "grant", "none", cyc);
        end
      end
      // RAM bus
      while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        fail_event("access_missing", "none", "access", acc_q[0].cyc);
        void'(acc_q.pop_front());
      end
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        e = acc_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(e.addr));
        check("mem_we", 64'(mem_we), 64'(e.we));
        if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.data));
      end else begin
        check("mem_idle_we", 64'(mem_we), 64'(0));
      end
      // display returns
      while (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
        fail_event("disp_missing", "none", "disp_valid", disp_q[0].cyc);
        void'(disp_q.pop_front());
      end
      if (disp_valid) begin
        if (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
          e = disp_q.pop_front();
          check("disp_data", 64'(disp_data), 64'(e.data));
        end else begin
          fail_event("disp_unexpected", "disp_valid", "none", cyc);
        end
      end
      // host read returns
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        fail_event("rvalid_missing", "none", "h_rvalid", rd_q[0].cyc);
        void'(rd_q.pop_front());
      end
      if (h_rvalid != 2'b00) begin
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
          e = rd_q.pop_front();
          check("h_rvalid", 64'(h_rvalid), 64'(2'b01 << e.host));
          check("h_rdata", 64'(h_rdata), 64'(e.data));
        end else begin
          fail_event("rvalid_unexpected", "h_rvalid", "none", cyc);
        end
      end
    end
  end

  // ---------------- reference model and stimulus ----------------
  logic [DW-1:0] model_ram [MEM_SZ];
  int            dptr = 0;      // next display word
  int            rr = 0;        // host preferred when both ask
  logic [1:0]    hreq = '0;
  logic [1:0]    hwe = '0;
  logic [AW-1:0] haddr [2];
  logic [DW-1:0] hwd [2];
  int            req_pct = 0;

  task automatic arm_random();
    for (int i = 0; i < 2; i++) begin
      if (!hreq[i] && $urandom_range(99) < 32'(req_pct)) begin
        hreq[i]  = 1'b1;
        hwe[i]   = 1'($urandom_range(1));
        haddr[i] = ($urandom_range(1) == 0) ? AW'($urandom_range(TB_FB - 1))
                                            : AW'(32'h100 + $urandom_range(15));
        hwd[i]   = DW'($urandom);
      end
    end
  endtask

  // Drive one cycle, predict what the arbiter must do with it, then advance.
  task automatic step(input logic pt, input logic vo, input logic fs);
    int   a;
    int   h;
    exp_t e;
    pixel_tick  = pt;
    video_on    = vo;
    frame_start = fs;
    h_req       = hreq;
    h_we        = hwe;
    h_addr0     = haddr[0];
    h_addr1     = haddr[1];
    h_wdata0    = hwd[0];
    h_wdata1    = hwd[1];
    if (!reset) begin
      if (pt && vo) begin
        a    = fs ? 0 : dptr;
        dptr = (a + 1) % TB_FB;
        e = '{cyc + 1, 0, AW'(a), 1'b0, DW'(0)};
        acc_q.push_back(e);
        e = '{cyc + 2, 0, AW'(0), 1'b0, model_ram[a]};
        disp_q.push_back(e);
      end else begin
        if (fs) dptr = 0;
        h = -1;
        if (hreq == 2'b11) h = RR_MODE ? rr : 0;
        else if (hreq[0]) h = 0;
        else if (hreq[1]) h = 1;
        if (h >= 0) begin
          if (RR_MODE) rr = 1 - h;
          e = '{cyc, h, AW'(0), 1'b0, DW'(0)};
          gnt_q.push_back(e);
          if (hwe[h]) begin
            model_ram[haddr[h]] = hwd[h];
            e = '{cyc + 1, h, haddr[h], 1'b1, hwd[h]};
            acc_q.push_back(e);
          end else begin
            e = '{cyc + 1, h, haddr[h], 1'b0, DW'(0)};
            acc_q.push_back(e);
            e = '{cyc + 2, h, AW'(0), 1'b0, model_ram[haddr[h]]};
            rd_q.push_back(e);
          end
          hreq[h] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Hold reset for n cycles with requests and display slots active; any
  // in-flight return is expected to vanish.
  task automatic do_reset(input int n);
    reset = 1'b1;
    gnt_q.delete();
    acc_q.delete();
    disp_q.delete();
    rd_q.delete();
    dptr = 0;
    rr   = 0;
    hreq = 2'b11;
    hwe  = 2'b00;
    repeat (n) step(1'b1, 1'b1, 1'b0);
    hreq  = 2'b00;
    reset = 1'b0;
  endtask

  task automatic drain();
    req_pct = 0;
    for (int i = 0; i < 20 && hreq != 2'b00; i++) step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic pt_r;
    logic vo_r;
    for (int i = 0; i < MEM_SZ; i++) model_ram[i] = init_val(i);
    haddr[0] = '0; haddr[1] = '0; hwd[0] = '0; hwd[1] = '0;
    #1;
    do_reset(3);

    // Display fetch of words 0..3, no host traffic.
    for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b1, 1'b0);

    // Host 0 writes 0xA5 to 0x100 arriving on a display slot, then reads it back.
    hreq = 2'b01; hwe = 2'b01; haddr[0] = AW'(32'h100); hwd[0] = 8'hA5;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    hreq = 2'b01; hwe = 2'b00; haddr[0] = AW'(32'h100);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain();

    // Both hosts requesting continuously during blanking.
    req_pct = 100;
    for (int i = 0; i < 10; i++) begin
      arm_random();
      step(1'b0, 1'b0, 1'b0);
    end
    drain();

    // Scan past the end of the frame with light host traffic.
    req_pct = 30;
    for (int i = 0; i < 2 * TB_FB + 20; i++) begin
      arm_random();
      step(i % 2 == 0, 1'b1, 1'b0);
    end
    drain();

    // frame_start on a display slot, then on a non-display cycle.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);

    // Random traffic with video_on runs and occasional frame_start.
    req_pct = 60;
    pt_r = 1'b0;
    vo_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      arm_random();
      pt_r = ~pt_r;
      if ($urandom_range(63) == 0) vo_r = ~vo_r;
      step(pt_r, vo_r, 1'($urandom_range(399) == 0));
    end
    drain();

    // Host 1 read granted, reset asserted the very next cycle.
    hreq = 2'b10; hwe = 2'b00; haddr[1] = AW'(32'h105);
    step(1'b0, 1'b0, 1'b0);
    do_reset(3);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // Display restarts at word 0 after reset.
    step(1'b1, 1'b1, 1'b0);
    drain();

    @(negedge clk);
    #1;
    check("queues_empty", 64'(gnt_q.size() + acc_q.size() + disp_q.size() + rd_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
